game_session: RTL and testbench

Main-game session controller; the responder side of the menu start handshake. It accepts `i_main_start` from the menu and clears the per-session score RAM. It then answers with `o_main_ready` and runs the countdown / play / pause / game-over sequence, counting frames and tracking time, lives and score. It sits between the menu and the stage/sprite logic, which consume its status outputs.

---
 rtl/game_session.sv | 163 ++++++++++++++++
 tb/tb_game_session.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_session.sv
// Main-game session controller: answers the menu start handshake, clears the
// score RAM, then sequences countdown / play / pause / game-over.
module game_session #(
    parameter int FPS               = 60,
    parameter int GAME_SECONDS      = 99,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int LIVES             = 3,
    parameter int INIT_DEPTH        = 16
) (
    input  logic                          i_clk_pix,
    input  logic                          i_rst_n,
    input  logic                          i_frame,
    input  logic                          i_main_start,
    input  logic [2:0]                    i_key,
    input  logic                          i_hit,
    input  logic [7:0]                    i_score_inc,
    output logic                          o_main_ready,
    output logic [2:0]                    o_state,
    output logic                          o_playing,
    output logic                          o_paused,
    output logic                          o_game_over,
    output logic [3:0]                    o_countdown,
    output logic [7:0]                    o_time_left,
    output logic [3:0]                    o_lives,
    output logic [15:0]                   o_score,
    output logic                          o_clr_we,
    output logic [$clog2(INIT_DEPTH)-1:0] o_clr_addr
);

    localparam int FW = (FPS > 1) ? $clog2(FPS) : 1;
    localparam int AW = $clog2(INIT_DEPTH);
    localparam logic [FW-1:0] FC_LAST   = FW'(FPS - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(INIT_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_READY     = 3'd2,
        S_COUNTDOWN = 3'd3,
        S_PLAY      = 3'd4,
        S_PAUSE     = 3'd5,
        S_OVER      = 3'd6
    } state_t;

    state_t          state, state_nxt;
    logic [FW-1:0]   fc, fc_nxt;
    logic [3:0]      cd_nxt;
    logic [7:0]      time_nxt;
    logic [3:0]      lives_nxt;
    logic [15:0]     score_nxt;
    logic            clr_we_nxt;
    logic [AW-1:0]   clr_addr_nxt;
    logic [1:0]      key_prev;
    logic            pause_edge, start_edge, frame_wrap, go_init;
    logic [16:0]     score_sum;
    logic            unused_key;

    assign unused_key = i_key[2];
    assign o_state    = state;

    always_comb begin
        pause_edge   = i_key[1] & ~key_prev[1];
        start_edge   = i_key[0] & ~key_prev[0];
        frame_wrap   = i_frame && (fc == FC_LAST);
        score_sum    = {1'b0, o_score} + {9'd0, i_score_inc};
        go_init      = 1'b0;
        state_nxt    = state;
        fc_nxt       = fc;
        cd_nxt       = o_countdown;
        time_nxt     = o_time_left;
        lives_nxt    = o_lives;
        score_nxt    = o_score;
        clr_we_nxt   = o_clr_we;
        clr_addr_nxt = o_clr_addr;

        case (state)
            S_IDLE: if (i_main_start) go_init = 1'b1;
            S_INIT: begin
                if (o_clr_addr == ADDR_LAST) begin
                    state_nxt    = S_READY;
                    clr_we_nxt   = 1'b0;
                    clr_addr_nxt = '0;
                end else begin
                    clr_addr_nxt = o_clr_addr + AW'(1);
                end
            end
            S_READY: if (!i_main_start) state_nxt = S_COUNTDOWN;
            S_COUNTDOWN: begin
                if (frame_wrap) begin
                    fc_nxt = '0;
                    if (o_countdown <= 4'd1) begin
                        cd_nxt    = '0;
                        state_nxt = S_PLAY;
                    end else begin
                        cd_nxt = o_countdown - 4'd1;
                    end
                end else if (i_frame) begin
                    fc_nxt = fc + FW'(1);
                end
            end
            S_PLAY: begin
                if (frame_wrap) begin
                    fc_nxt = '0;
                    if (o_time_left != 8'd0) time_nxt = o_time_left - 8'd1;
                end else if (i_frame) begin
                    fc_nxt = fc + FW'(1);
                end
                if (i_hit && o_lives != 4'd0) lives_nxt = o_lives - 4'd1;
                score_nxt = score_sum[16] ? '1 : score_sum[15:0];
                // Game-over takes priority over a same-cycle pause request.
                if (lives_nxt == 4'd0 || time_nxt == 8'd0) state_nxt = S_OVER;
                else if (pause_edge)                       state_nxt = S_PAUSE;
            end
            S_PAUSE: if (pause_edge) state_nxt = S_PLAY;
            S_OVER:  if (start_edge) go_init = 1'b1;
            default: state_nxt = S_IDLE;
        endcase

        if (go_init) begin
            state_nxt    = S_INIT;
            clr_we_nxt   = 1'b1;
            clr_addr_nxt = '0;
            fc_nxt       = '0;
            cd_nxt       = 4'(COUNTDOWN_SECONDS);
            time_nxt     = 8'(GAME_SECONDS);
            lives_nxt    = 4'(LIVES);
            score_nxt    = '0;
        end
    end

    always_ff @(posedge i_clk_pix) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            fc           <= '0;
            key_prev     <= '0;
            o_countdown  <= '0;
            o_time_left  <= '0;
            o_lives      <= '0;
            o_score      <= '0;
            o_clr_we     <= 1'b0;
            o_clr_addr   <= '0;
            o_main_ready <= 1'b0;
            o_playing    <= 1'b0;
            o_paused     <= 1'b0;
            o_game_over  <= 1'b0;
        end else begin
            state        <= state_nxt;
            fc           <= fc_nxt;
            key_prev     <= i_key[1:0];
            o_countdown  <= cd_nxt;
            o_time_left  <= time_nxt;
            o_lives      <= lives_nxt;
            o_score      <= score_nxt;
            o_clr_we     <= clr_we_nxt;
            o_clr_addr   <= clr_addr_nxt;
            o_main_ready <= (state_nxt == S_READY);
            o_playing    <= (state_nxt == S_PLAY);
            o_paused     <= (state_nxt == S_PAUSE);
            o_game_over  <= (state_nxt == S_OVER);
        end
    end

endmodule

// File: tb/tb_game_session.sv
// Directed self-checking bench for game_session with a short game
// (FPS=4, GAME_SECONDS=2, COUNTDOWN_SECONDS=3, LIVES=3, INIT_DEPTH=16).
module tb_game_session;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_frame = 1'b0;
    logic        i_main_start = 1'b0;
    logic [2:0]  i_key = '0;
    logic        i_hit = 1'b0;
    logic [7:0]  i_score_inc = '0;
    logic        o_main_ready, o_playing, o_paused, o_game_over, o_clr_we;
    logic [2:0]  o_state;
    logic [3:0]  o_countdown, o_lives, o_clr_addr;
    logic [7:0]  o_time_left;
    logic [15:0] o_score;

    int total = 0;
    int bad   = 0;

    game_session #(
        .FPS(4), .GAME_SECONDS(2), .COUNTDOWN_SECONDS(3), .LIVES(3), .INIT_DEPTH(16)
    ) dut (
        .i_clk_pix(clk), .i_rst_n(i_rst_n), .i_frame(i_frame), .i_main_start(i_main_start),
        .i_key(i_key), .i_hit(i_hit), .i_score_inc(i_score_inc),
        .o_main_ready(o_main_ready), .o_state(o_state), .o_playing(o_playing),
        .o_paused(o_paused), .o_game_over(o_game_over), .o_countdown(o_countdown),
        .o_time_left(o_time_left), .o_lives(o_lives), .o_score(o_score),
        .o_clr_we(o_clr_we), .o_clr_addr(o_clr_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        i_frame = 1'b1;
        step();
        i_frame = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        step(); step();
        total++; if (o_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", o_state); end
        total++; if ({o_main_ready, o_playing, o_paused, o_game_over, o_clr_we} !== 5'd0) begin bad++;
            $display("FAIL reset_flags got=%b exp=00000", {o_main_ready, o_playing, o_paused, o_game_over, o_clr_we}); end
        total++; if ({o_countdown, o_time_left, o_lives, o_score, o_clr_addr} !== 36'd0) begin bad++;
            $display("FAIL reset_counters got=%h exp=0", {o_countdown, o_time_left, o_lives, o_score, o_clr_addr}); end
        i_rst_n = 1'b1;
        step();
        total++; if (o_state !== 3'd0) begin bad++; $display("FAIL idle_hold got=%0d exp=0", o_state); end
    endtask

    task automatic test_handshake();
        i_main_start = 1'b1;
        step();
        total++; if ({o_state, o_clr_we, o_clr_addr} !== {3'd1, 1'b1, 4'd0}) begin bad++;
            $display("FAIL init_entry got=%h exp=%h", {o_state, o_clr_we, o_clr_addr}, {3'd1, 1'b1, 4'd0}); end
        total++; if ({o_score, o_lives, o_time_left, o_countdown} !== {16'd0, 4'd3, 8'd2, 4'd3}) begin bad++;
            $display("FAIL init_load got=%h exp=%h", {o_score, o_lives, o_time_left, o_countdown}, {16'd0, 4'd3, 8'd2, 4'd3}); end
        for (int i = 1; i < 16; i++) begin
            step();
            total++; if ({o_state, o_clr_we, o_main_ready, o_clr_addr} !== {3'd1, 1'b1, 1'b0, 4'(i)}) begin bad++;
                $display("FAIL init_addr%0d got=%h exp=%h", i, {o_state, o_clr_we, o_main_ready, o_clr_addr}, {3'd1, 1'b1, 1'b0, 4'(i)}); end
        end
        step();
        total++; if ({o_state, o_main_ready, o_clr_we} !== {3'd2, 1'b1, 1'b0}) begin bad++;
            $display("FAIL ready_rise got=%b exp=%b", {o_state, o_main_ready, o_clr_we}, {3'd2, 1'b1, 1'b0}); end
        step(); step();
        total++; if ({o_state, o_main_ready} !== {3'd2, 1'b1}) begin bad++;
            $display("FAIL ready_hold got=%b exp=%b", {o_state, o_main_ready}, {3'd2, 1'b1}); end
        i_main_start = 1'b0;
        step();
        total++; if ({o_state, o_main_ready, o_countdown} !== {3'd3, 1'b0, 4'd3}) begin bad++;
            $display("FAIL ready_fall got=%h exp=%h", {o_state, o_main_ready, o_countdown}, {3'd3, 1'b0, 4'd3}); end
    endtask

    task automatic test_countdown();
        int exp_cd, exp_st;
        for (int k = 1; k <= 12; k++) begin
            if (k == 1) i_score_inc = 8'd9;
            frame();
            i_score_inc = '0;
            step();
            exp_cd = (k >= 12) ? 0 : 3 - k / 4;
            exp_st = (k >= 12) ? 4 : 3;
            total++; if ({o_state, o_countdown} !== {3'(exp_st), 4'(exp_cd)}) begin bad++;
                $display("FAIL countdown_f%0d got st=%0d cd=%0d exp st=%0d cd=%0d", k, o_state, o_countdown, exp_st, exp_cd); end
        end
        total++; if ({o_playing, o_score, o_time_left} !== {1'b1, 16'd0, 8'd2}) begin bad++;
            $display("FAIL play_entry got=%h exp=%h", {o_playing, o_score, o_time_left}, {1'b1, 16'd0, 8'd2}); end
    endtask

    task automatic test_pause();
        frame(); frame();
        total++; if (o_time_left !== 8'd2) begin bad++; $display("FAIL pre_pause_time got=%0d exp=2", o_time_left); end
        i_key = 3'b010;
        step();
        total++; if ({o_state, o_paused, o_playing} !== {3'd5, 1'b1, 1'b0}) begin bad++;
            $display("FAIL pause_enter got=%b exp=%b", {o_state, o_paused, o_playing}, {3'd5, 1'b1, 1'b0}); end
        for (int i = 0; i < 10; i++) begin
            i_frame = 1'b1; i_hit = (i == 4); i_score_inc = 8'd7;
            step();
        end
        i_frame = 1'b0; i_hit = 1'b0; i_score_inc = '0;
        total++; if ({o_state, o_time_left, o_lives, o_score} !== {3'd5, 8'd2, 4'd3, 16'd0}) begin bad++;
            $display("FAIL pause_frozen got=%h exp=%h", {o_state, o_time_left, o_lives, o_score}, {3'd5, 8'd2, 4'd3, 16'd0}); end
        i_key = 3'b000;
        step();
        total++; if (o_state !== 3'd5) begin bad++; $display("FAIL pause_release got=%0d exp=5", o_state); end
        i_key = 3'b010;
        step();
        i_key = 3'b000;
        total++; if ({o_state, o_playing} !== {3'd4, 1'b1}) begin bad++;
            $display("FAIL pause_resume got=%b exp=%b", {o_state, o_playing}, {3'd4, 1'b1}); end
        frame();
        total++; if (o_time_left !== 8'd2) begin bad++; $display("FAIL resume_f3_time got=%0d exp=2", o_time_left); end
        frame();
        total++; if ({o_state, o_time_left} !== {3'd4, 8'd1}) begin bad++;
            $display("FAIL resume_wrap got st=%0d t=%0d exp st=4 t=1", o_state, o_time_left); end
    endtask

    task automatic test_score_sat();
        i_score_inc = 8'd255;
        repeat (256) step();
        total++; if (o_score !== 16'hFF00) begin bad++; $display("FAIL score_ff00 got=%h exp=ff00", o_score); end
        step();
        total++; if (o_score !== 16'hFFFF) begin bad++; $display("FAIL score_ffff got=%h exp=ffff", o_score); end
        step();
        i_score_inc = '0;
        step();
        total++; if ({o_score, o_state, o_time_left} !== {16'hFFFF, 3'd4, 8'd1}) begin bad++;
            $display("FAIL score_stick got=%h exp=%h", {o_score, o_state, o_time_left}, {16'hFFFF, 3'd4, 8'd1}); end
    endtask

    task automatic test_timer_over();
        for (int k = 1; k <= 3; k++) begin
            frame();
            total++; if ({o_state, o_time_left} !== {3'd4, 8'd1}) begin bad++;
                $display("FAIL timer_f%0d got st=%0d t=%0d exp st=4 t=1", k, o_state, o_time_left); end
        end
        frame();
        total++; if ({o_state, o_time_left, o_game_over, o_playing} !== {3'd6, 8'd0, 1'b1, 1'b0}) begin bad++;
            $display("FAIL timer_over got=%h exp=%h", {o_state, o_time_left, o_game_over, o_playing}, {3'd6, 8'd0, 1'b1, 1'b0}); end
        i_frame = 1'b1; i_hit = 1'b1; i_score_inc = 8'd5; i_key = 3'b010;
        step();
        i_frame = 1'b0; i_hit = 1'b0; i_score_inc = '0; i_key = 3'b000;
        step();
        total++; if ({o_state, o_lives, o_score, o_time_left} !== {3'd6, 4'd3, 16'hFFFF, 8'd0}) begin bad++;
            $display("FAIL over_frozen got=%h exp=%h", {o_state, o_lives, o_score, o_time_left}, {3'd6, 4'd3, 16'hFFFF, 8'd0}); end
    endtask

    task automatic test_restart();
        i_key = 3'b001;
        step();
        i_key = 3'b000;
        total++; if ({o_state, o_clr_we, o_clr_addr, o_game_over} !== {3'd1, 1'b1, 4'd0, 1'b0}) begin bad++;
            $display("FAIL restart_init got=%h exp=%h", {o_state, o_clr_we, o_clr_addr, o_game_over}, {3'd1, 1'b1, 4'd0, 1'b0}); end
        total++; if ({o_score, o_lives, o_time_left, o_countdown} !== {16'd0, 4'd3, 8'd2, 4'd3}) begin bad++;
            $display("FAIL restart_load got=%h exp=%h", {o_score, o_lives, o_time_left, o_countdown}, {16'd0, 4'd3, 8'd2, 4'd3}); end
        repeat (15) step();
        total++; if ({o_state, o_clr_addr} !== {3'd1, 4'd15}) begin bad++;
            $display("FAIL restart_last_addr got=%h exp=%h", {o_state, o_clr_addr}, {3'd1, 4'd15}); end
        step();
        total++; if ({o_state, o_main_ready} !== {3'd2, 1'b1}) begin bad++;
            $display("FAIL restart_ready got=%b exp=%b", {o_state, o_main_ready}, {3'd2, 1'b1}); end
        step();
        total++; if ({o_state, o_main_ready} !== {3'd3, 1'b0}) begin bad++;
            $display("FAIL restart_countdown got=%b exp=%b", {o_state, o_main_ready}, {3'd3, 1'b0}); end
    endtask

    task automatic test_lives();
        repeat (12) frame();
        total++; if (o_state !== 3'd4) begin bad++; $display("FAIL game2_play got=%0d exp=4", o_state); end
        i_hit = 1'b1; step(); i_hit = 1'b0;
        total++; if ({o_state, o_lives} !== {3'd4, 4'd2}) begin bad++;
            $display("FAIL hit1 got st=%0d l=%0d exp st=4 l=2", o_state, o_lives); end
        step();
        i_hit = 1'b1; step(); i_hit = 1'b0;
        total++; if ({o_state, o_lives} !== {3'd4, 4'd1}) begin bad++;
            $display("FAIL hit2 got st=%0d l=%0d exp st=4 l=1", o_state, o_lives); end
        i_hit = 1'b1; i_score_inc = 8'd200; i_key = 3'b010;
        step();
        i_hit = 1'b0; i_score_inc = '0; i_key = 3'b000;
        total++; if ({o_state, o_lives, o_score} !== {3'd6, 4'd0, 16'd200}) begin bad++;
            $display("FAIL hit3_over got=%h exp=%h", {o_state, o_lives, o_score}, {3'd6, 4'd0, 16'd200}); end
        total++; if ({o_game_over, o_paused, o_playing} !== 3'b100) begin bad++;
            $display("FAIL hit3_flags got=%b exp=100", {o_game_over, o_paused, o_playing}); end
    endtask

    task automatic test_reset_mid_init();
        step();
        i_key = 3'b001;
        step();
        i_key = 3'b000;
        step(); step(); step();
        total++; if ({o_state, o_clr_we, o_clr_addr} !== {3'd1, 1'b1, 4'd3}) begin bad++;
            $display("FAIL midinit_addr got=%h exp=%h", {o_state, o_clr_we, o_clr_addr}, {3'd1, 1'b1, 4'd3}); end
        i_rst_n = 1'b0;
        step();
        total++; if ({o_state, o_clr_we, o_clr_addr, o_main_ready, o_game_over} !== 9'd0) begin bad++;
            $display("FAIL midinit_reset_ctl got=%b exp=0", {o_state, o_clr_we, o_clr_addr, o_main_ready, o_game_over}); end
        total++; if ({o_countdown, o_time_left, o_lives, o_score} !== 32'd0) begin bad++;
            $display("FAIL midinit_reset_cnt got=%h exp=0", {o_countdown, o_time_left, o_lives, o_score}); end
        i_rst_n = 1'b1;
        step();
        total++; if (o_state !== 3'd0) begin bad++; $display("FAIL post_reset_idle got=%0d exp=0", o_state); end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_countdown();
        test_pause();
        test_score_sat();
        test_timer_over();
        test_restart();
        test_lives();
        test_reset_mid_init();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
